// File: rtl/framebuffer_scanout.sv
// Upscaling framebuffer scanout: replicated BRAM reads, RGB565->RGB888, sync strobes kept aligned.
// Latency MEM_LATENCY+2 cycles from timing inputs to colour/strobes; no backpressure, it follows the raster.
module framebuffer_scanout #(
    parameter int ACTIVE_H_PIXELS = 1280,
    parameter int ACTIVE_LINES    = 720,
    parameter int TOTAL_PIXELS    = 1650,
    parameter int TOTAL_LINES     = 750,
    parameter int FB_WIDTH        = 320,
    parameter int FB_HEIGHT       = 180,
    parameter int SCALE           = 4,
    parameter int MEM_LATENCY     = 2
) (
    input  logic                                   clk_pixel_in,
    input  logic                                   rst_n_in,
    input  logic [$clog2(TOTAL_PIXELS)-1:0]        hcount_in,
    input  logic [$clog2(TOTAL_LINES)-1:0]         vcount_in,
    input  logic                                   hs_in,
    input  logic                                   vs_in,
    input  logic                                   ad_in,
    input  logic                                   nf_in,
    output logic [$clog2(FB_WIDTH*FB_HEIGHT)-1:0]  addr_out,
    output logic                                   rd_en_out,
    input  logic [15:0]                            data_in,
    output logic [7:0]                             red_out,
    output logic [7:0]                             green_out,
    output logic [7:0]                             blue_out,
    output logic                                   hs_out,
    output logic                                   vs_out,
    output logic                                   ad_out,
    output logic                                   nf_out
);
    localparam int HW = $clog2(TOTAL_PIXELS);
    localparam int AW = $clog2(FB_WIDTH * FB_HEIGHT);
    localparam int XW = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
    localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int DL = MEM_LATENCY + 2;
    localparam logic [HW-1:0] H_LAST   = HW'(ACTIVE_H_PIXELS - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(SCALE - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(FB_WIDTH);
    localparam logic CFG_OK = (FB_WIDTH * SCALE == ACTIVE_H_PIXELS) && (FB_HEIGHT * SCALE == ACTIVE_LINES);

    typedef enum logic {WAIT_FRAME, SCAN} state_t;

    state_t               state, state_nxt;
    logic                 issue;
    logic [SW-1:0]        sx, sy;
    logic [XW-1:0]        fx;
    logic [AW-1:0]        line_base;
    logic [MEM_LATENCY-1:0] rd_pipe;
    logic [DL-1:0][3:0]   strb_pipe;

    // Vertical position is tracked from end-of-line events, so vcount is not needed.
    logic unused_inputs;
    assign unused_inputs = ^{vcount_in, CFG_OK};

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= WAIT_FRAME;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            WAIT_FRAME: if (nf_in) state_nxt = SCAN;
            SCAN:       issue = ad_in;
            default:    state_nxt = WAIT_FRAME;
        endcase
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_out  <= '0;
            rd_en_out <= 1'b0;
            sx        <= '0;
            fx        <= '0;
            sy        <= '0;
            line_base <= '0;
        end else begin
            rd_en_out <= issue;
            if (issue) begin
                addr_out <= line_base + AW'(fx);
                if (sx == S_LAST) begin
                    sx <= '0;
                    fx <= fx + XW'(1);
                end else begin
                    sx <= sx + SW'(1);
                end
            end else begin
                sx <= '0;
                fx <= '0;
            end
            // A new frame wins over the end-of-line row advance.
            if (nf_in) begin
                sy        <= '0;
                line_base <= '0;
            end else if (issue && hcount_in == H_LAST) begin
                if (sy == S_LAST) begin
                    sy        <= '0;
                    line_base <= line_base + ROW_STEP;
                end else begin
                    sy <= sy + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_pipe   <= '0;
            strb_pipe <= '0;
            red_out   <= '0;
            green_out <= '0;
            blue_out  <= '0;
        end else begin
            rd_pipe[0] <= rd_en_out;
            for (int k = 1; k < MEM_LATENCY; k++) rd_pipe[k] <= rd_pipe[k-1];
            strb_pipe[0] <= {hs_in, vs_in, ad_in, nf_in};
            for (int k = 1; k < DL; k++) strb_pipe[k] <= strb_pipe[k-1];
            // rd_pipe tail marks data_in words that belong to an issued read.
            if (rd_pipe[MEM_LATENCY-1]) begin
                red_out   <= {data_in[15:11], data_in[15:13]};
                green_out <= {data_in[10:5],  data_in[10:9]};
                blue_out  <= {data_in[4:0],   data_in[4:2]};
            end else begin
                red_out   <= '0;
                green_out <= '0;
                blue_out  <= '0;
            end
        end
    end

    assign hs_out = strb_pipe[DL-1][3];
    assign vs_out = strb_pipe[DL-1][2];
    assign ad_out = strb_pipe[DL-1][1];
    assign nf_out = strb_pipe[DL-1][0];

endmodule

// File: doc/framebuffer_scanout.md
# framebuffer_scanout

Downstream stage of the video timing generator: consumes its pixel/line counters and sync/active/new-frame strobes, generates read addresses into a low-resolution framebuffer BRAM with integer pixel replication (upscaling), expands returned RGB565 words to 24-bit colour, and delays the sync strobes so they stay aligned with the colour data. Its output drives the TMDS/HDMI encoder stage directly.

## Interface
- ACTIVE_H_PIXELS, 1280, active pixels per line of the output raster
- ACTIVE_LINES, 720, active lines per output frame
- TOTAL_PIXELS, 1650, total pixels per line; sets hcount_in width
- TOTAL_LINES, 750, total lines per frame; sets vcount_in width
- FB_WIDTH, 320, framebuffer width in pixels; must equal ACTIVE_H_PIXELS/SCALE
- FB_HEIGHT, 180, framebuffer height in lines; must equal ACTIVE_LINES/SCALE
- SCALE, 4, replication factor in both axes, ≥1
- MEM_LATENCY, 2, BRAM read latency in cycles from addr_out to data_in, ≥1

- clk_pixel_in  input  1  pixel clock; the only clock
- rst_n_in  input  1  reset, asynchronous assert, active-low
- hcount_in  input  $clog2(TOTAL_PIXELS)  current pixel column
- vcount_in  input  $clog2(TOTAL_LINES)  current line
- hs_in, vs_in, ad_in, nf_in  input  1 each  hsync, vsync, active-display, new-frame pulse from timing generator
- addr_out  output  $clog2(FB_WIDTH*FB_HEIGHT)  framebuffer read address
- rd_en_out  output  1  read enable for addr_out
- data_in  input  16  RGB565 word, valid MEM_LATENCY cycles after addr_out/rd_en_out
- red_out, green_out, blue_out  output  8 each  expanded colour
- hs_out, vs_out, ad_out, nf_out  output  1 each  input strobes delayed by pipeline latency

## Operation
- State machine, two states: WAIT_FRAME (reset state) and SCAN.
  - WAIT_FRAME: rd_en_out=0, colour forced to 0; counters held at 0. On nf_in=1 → SCAN.
  - SCAN: address generation active; stays in SCAN until reset.
- Counters (SCAN): sx (0..SCALE-1), fx (0..FB_WIDTH-1), sy (0..SCALE-1), line_base (0..(FB_HEIGHT-1)*FB_WIDTH). No multiplier; line_base advances by addition.
- Each cycle with ad_in=1: addr_out <= line_base + fx; rd_en_out <= 1; sx increments; on sx==SCALE-1, sx←0 and fx increments.
- Each cycle with ad_in=0: rd_en_out <= 0; sx←0, fx←0; addr_out holds last value.
- End of active line (ad_in=1 and hcount_in==ACTIVE_H_PIXELS-1): sy increments; on sy==SCALE-1, sy←0 and line_base += FB_WIDTH.
- nf_in=1 (any state): sy←0, line_base←0. nf_in has priority over end-of-line update in the same cycle.
- Colour expansion (registered): red={d[15:11],d[15:13]}, green={d[10:5],d[10:9]}, blue={d[4:0],d[4:2]}; when delayed ad is 0 or state is WAIT_FRAME at issue time, colour = 0.
- line_base never exceeds (FB_HEIGHT-1)*FB_WIDTH when parameters satisfy the equality constraints; no wrap logic beyond nf_in reset.

## Timing
- Input sample at cycle t → addr_out/rd_en_out at t+1 → data_in valid at t+1+MEM_LATENCY → colour outputs at t+2+MEM_LATENCY.
- hs/vs/ad/nf_out are hs/vs/ad/nf_in delayed exactly MEM_LATENCY+2 cycles via a shift register; identical latency for all four and colour.
- Reset values (asynchronous, while rst_n_in=0): all outputs 0, addr_out=0, all counters 0, delay lines cleared, state WAIT_FRAME.
- Reset deasserted mid-frame: no reads, black output, delayed strobes still propagate (delayed copies of inputs); first read issued on first ad_in=1 after the next nf_in.
- data_in is ignored when its corresponding rd_en_out was 0.

## Test plan
- Reset release then drive timing generator defaults: no rd_en_out and rgb=0 until first nf_in; strobes appear delayed by 4 cycles (MEM_LATENCY=2).
- First active line after nf_in: addr_out sequence 0,0,0,0,1,1,1,1,…,319 (×4); hcount_in=1279 maps to addr 319; rd_en_out low in blanking.
- Lines 0–3 issue base 0, line 4 base 320, line 719 base 57280, last address 57599; next frame restarts at 0.
- BRAM model returning data_in=16'hF800 → red_out=8'hFF, green=0, blue=0; 16'h07E0 → green=8'hFF; 16'h0841 → rgb=(8'h08,8'h08,8'h08).
- Assert rst_n_in low mid-line 300 for 3 cycles: outputs go 0 asynchronously; no reads until next nf_in; next frame addresses correct from 0.
- SCALE=1, FB_WIDTH=1280, FB_HEIGHT=720, MEM_LATENCY=1: addr_out increments every active cycle, last address 921599, output latency 3 cycles.
